// File: rtl/angle_search.sv
// ============================================================================
//  Module   : angle_search (with sin_lookup, cos_lookup)
//  Purpose  : Sequential search for the 0..176 step-4 angle code whose line
//             direction best matches (dx, dy); optional ANGLE_SEARCH_EARLY_EXIT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sin_lookup (
   input  logic [7:0]  angle_i,
   output logic [12:0] mag_o,
   output logic        neg_o
);
   logic [7:0] fold;

   always_comb begin
      fold  = (angle_i > 8'd90) ? (8'd180 - angle_i) : angle_i;
      neg_o = 1'b0;
      case (fold)
         8'd0:    mag_o = 13'd0;     8'd4:  mag_o = 13'd286;  8'd8:  mag_o = 13'd570;
         8'd12:   mag_o = 13'd852;   8'd16: mag_o = 13'd1129; 8'd20: mag_o = 13'd1401;
         8'd24:   mag_o = 13'd1666;  8'd28: mag_o = 13'd1923; 8'd32: mag_o = 13'd2171;
         8'd36:   mag_o = 13'd2408;  8'd40: mag_o = 13'd2633; 8'd44: mag_o = 13'd2845;
         8'd48:   mag_o = 13'd3044;  8'd52: mag_o = 13'd3228; 8'd56: mag_o = 13'd3396;
         8'd60:   mag_o = 13'd3547;  8'd64: mag_o = 13'd3681; 8'd68: mag_o = 13'd3798;
         8'd72:   mag_o = 13'd3896;  8'd76: mag_o = 13'd3974; 8'd80: mag_o = 13'd4034;
         8'd84:   mag_o = 13'd4074;  8'd88: mag_o = 13'd4094;
         default: mag_o = 13'd0;
      endcase
   end
endmodule

module cos_lookup (
   input  logic [7:0]  angle_i,
   output logic [12:0] mag_o,
   output logic        neg_o
);
   logic [7:0] fold;

   always_comb begin
      fold  = (angle_i > 8'd90) ? (8'd180 - angle_i) : angle_i;
      neg_o = (angle_i > 8'd90);
      case (fold)
         8'd0:    mag_o = 13'd4096;  8'd4:  mag_o = 13'd4086; 8'd8:  mag_o = 13'd4056;
         8'd12:   mag_o = 13'd4006;  8'd16: mag_o = 13'd3937; 8'd20: mag_o = 13'd3849;
         8'd24:   mag_o = 13'd3742;  8'd28: mag_o = 13'd3617; 8'd32: mag_o = 13'd3474;
         8'd36:   mag_o = 13'd3314;  8'd40: mag_o = 13'd3138; 8'd44: mag_o = 13'd2946;
         8'd48:   mag_o = 13'd2741;  8'd52: mag_o = 13'd2522; 8'd56: mag_o = 13'd2290;
         8'd60:   mag_o = 13'd2048;  8'd64: mag_o = 13'd1796; 8'd68: mag_o = 13'd1534;
         8'd72:   mag_o = 13'd1266;  8'd76: mag_o = 13'd991;  8'd80: mag_o = 13'd711;
         8'd84:   mag_o = 13'd428;   8'd88: mag_o = 13'd143;
         default: mag_o = 13'd0;
      endcase
   end
endmodule

module angle_search #(
   parameter int W = 12
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic signed [W-1:0] dx,
   input  logic signed [W-1:0] dy,
   output logic                busy,
   output logic                done,
   output logic [7:0]          angle,
   output logic [W+13:0]       residual
);
   typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [5:0]          k_q, k_d;
   logic signed [W:0]   x_q, x_d, y_q, y_d;
   logic [W+13:0]       best_q, best_d, res_q, res_d;
   logic [7:0]          best_ang_q, best_ang_d, angle_q, angle_d;

   logic [7:0]          cand;
   logic [12:0]         sin_mag, cos_mag;
   logic                sin_neg, cos_neg;
   logic signed [13:0]  s_val, c_val;
   logic signed [W:0]   ext_x, ext_y;
   logic signed [W+14:0] prod_s, prod_c, diff;
   logic [W+13:0]       r;
   logic                better, hit_zero, last;

   assign cand = {k_q, 2'b00};

   sin_lookup u_sin (.angle_i(cand), .mag_o(sin_mag), .neg_o(sin_neg));
   cos_lookup u_cos (.angle_i(cand), .mag_o(cos_mag), .neg_o(cos_neg));

   assign s_val  = sin_neg ? -$signed({1'b0, sin_mag}) : $signed({1'b0, sin_mag});
   assign c_val  = cos_neg ? -$signed({1'b0, cos_mag}) : $signed({1'b0, cos_mag});
   assign prod_s = (W+15)'(x_q) * (W+15)'(s_val);
   assign prod_c = (W+15)'(y_q) * (W+15)'(c_val);
   assign diff   = prod_s - prod_c;
   assign r      = diff[W+14] ? (W+14)'(-diff) : (W+14)'(diff);
   assign better = (r < best_q);

`ifdef ANGLE_SEARCH_EARLY_EXIT_EN
   assign hit_zero = (r == '0);
`else
   assign hit_zero = 1'b0;
`endif
   assign last  = (k_q == 6'd44) || hit_zero;

   // Extra sign bit lets -2^(W-1) be negated exactly during normalisation
   assign ext_x = (W+1)'(dx);
   assign ext_y = (W+1)'(dy);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         k_q        <= '0;
         x_q        <= '0;
         y_q        <= '0;
         best_q     <= '0;
         best_ang_q <= '0;
         angle_q    <= '0;
         res_q      <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         x_q        <= x_d;
         y_q        <= y_d;
         best_q     <= best_d;
         best_ang_q <= best_ang_d;
         angle_q    <= angle_d;
         res_q      <= res_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      x_d        = x_q;
      y_d        = y_q;
      best_d     = best_q;
      best_ang_d = best_ang_q;
      angle_d    = angle_q;
      res_d      = res_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               x_d     = ext_x;
               y_d     = ext_y;
               if (dy < 0) begin
                  x_d = -ext_x;
                  y_d = -ext_y;
               end else if ((dy == 0) && (dx < 0)) begin
                  x_d = -ext_x;
               end
               best_d  = '1;
               k_d     = '0;
               state_d = SEARCH;
            end else begin
               state_d = IDLE;
            end
         end
         SEARCH: begin
            if (better) begin
               best_d     = r;
               best_ang_d = cand;
            end
            if (last) begin
               angle_d = better ? cand : best_ang_q;
               res_d   = better ? r : best_q;
               k_d     = '0;
               state_d = DONE;
            end else begin
               k_d = k_q + 6'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q == SEARCH);
   assign done     = (state_q == DONE);
   assign angle    = angle_q;
   assign residual = res_q;
endmodule

`default_nettype wire
